// File: rtl/core_fetch_queue.sv
// Fetch queue: a single-outstanding L1I request FSM that feeds a DEPTH-entry instruction queue for decode.
// Optional feature: define CORE_FQ_BYPASS_EN to forward a response to decode in its arrival cycle when the queue is empty.
module core_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [31:0]             fq_pc_in,
    input  logic                    fq_pc_val_in,
    output logic                    fq_pc_rdy_out,
    input  logic                    fq_flush_in,
    output logic [31:0]             fq_l1i_addr_out,
    output logic                    fq_l1i_val_out,
    input  logic                    fq_l1i_ack_in,
    input  logic [31:0]             fq_l1i_rdata_in,
    input  logic                    fq_l1i_rvalid_in,
    output logic [31:0]             dec_instr_out,
    output logic [31:0]             dec_pc_out,
    output logic [31:0]             dec_pc_4_out,
    output logic                    dec_val_out,
    input  logic                    dec_rdy_in,
    output logic [$clog2(DEPTH):0]  fq_count_out
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t             state_q;
    logic [31:0]        req_pc_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        pc_mem_q    [DEPTH];
    logic [31:0]        instr_mem_q [DEPTH];

    logic pc_acc, rsp_ok, q_val, byp_val, push, pop;

    assign fq_pc_rdy_out = n_rst & (state_q == IDLE) & (count_q != CNT_W'(DEPTH)) & ~fq_flush_in;
    assign pc_acc        = fq_pc_val_in & fq_pc_rdy_out;
    assign rsp_ok        = (state_q == WAIT) & fq_l1i_rvalid_in & ~fq_flush_in;
    assign q_val         = (count_q != '0);

`ifdef CORE_FQ_BYPASS_EN
    assign byp_val = rsp_ok & ~q_val;
`else
    assign byp_val = 1'b0;
`endif

    // A bypassed response consumed by decode never occupies a queue slot.
    assign push = rsp_ok & ~(byp_val & dec_rdy_in);
    assign pop  = q_val & dec_rdy_in & ~fq_flush_in;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (pc_acc) begin
                    req_pc_q <= fq_pc_in;
                    state_q  <= REQ;
                end
                REQ: begin
                    if (fq_l1i_ack_in)    state_q <= fq_flush_in ? DROP : WAIT;
                    else if (fq_flush_in) state_q <= IDLE;
                end
                WAIT: begin
                    if (fq_l1i_rvalid_in) state_q <= IDLE;
                    else if (fq_flush_in) state_q <= DROP;
                end
                DROP: if (fq_l1i_rvalid_in && !fq_flush_in) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (fq_flush_in) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_d;
            end
        end
    end

    // NOTE: queue storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
            instr_mem_q[wr_ptr_q] <= fq_l1i_rdata_in;
        end
    end

    assign fq_l1i_val_out  = (state_q == REQ);
    assign fq_l1i_addr_out = req_pc_q;
    assign fq_count_out    = count_q;
    assign dec_val_out     = q_val | byp_val;

    always_comb begin
        dec_pc_out    = '0;
        dec_instr_out = '0;
        if (q_val) begin
            dec_pc_out    = pc_mem_q[rd_ptr_q];
            dec_instr_out = instr_mem_q[rd_ptr_q];
        end else if (byp_val) begin
            dec_pc_out    = req_pc_q;
            dec_instr_out = fq_l1i_rdata_in;
        end
    end

    assign dec_pc_4_out = dec_val_out ? dec_pc_out + 32'd4 : '0;
endmodule

// File: tb/tb_core_fetch_queue.sv
// Self-checking bench for core_fetch_queue: directed scenarios plus a randomized phase,
// all compared against a queue-based behavioural model of the fetch protocol.
module tb_core_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [31:0]   fq_pc_in = '0;
    logic          fq_pc_val_in = 1'b0;
    logic          fq_pc_rdy_out;
    logic          fq_flush_in = 1'b0;
    logic [31:0]   fq_l1i_addr_out;
    logic          fq_l1i_val_out;
    logic          fq_l1i_ack_in = 1'b0;
    logic [31:0]   fq_l1i_rdata_in = '0;
    logic          fq_l1i_rvalid_in = 1'b0;
    logic [31:0]   dec_instr_out, dec_pc_out, dec_pc_4_out;
    logic          dec_val_out;
    logic          dec_rdy_in = 1'b0;
    logic [CW-1:0] fq_count_out;

    core_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .fq_pc_in         (fq_pc_in),
        .fq_pc_val_in     (fq_pc_val_in),
        .fq_pc_rdy_out    (fq_pc_rdy_out),
        .fq_flush_in      (fq_flush_in),
        .fq_l1i_addr_out  (fq_l1i_addr_out),
        .fq_l1i_val_out   (fq_l1i_val_out),
        .fq_l1i_ack_in    (fq_l1i_ack_in),
        .fq_l1i_rdata_in  (fq_l1i_rdata_in),
        .fq_l1i_rvalid_in (fq_l1i_rvalid_in),
        .dec_instr_out    (dec_instr_out),
        .dec_pc_out       (dec_pc_out),
        .dec_pc_4_out     (dec_pc_4_out),
        .dec_val_out      (dec_val_out),
        .dec_rdy_in       (dec_rdy_in),
        .fq_count_out     (fq_count_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: where the single outstanding fetch stands, plus the list of delivered-but-unconsumed entries.
    typedef enum {P_NONE, P_ASK, P_AWAIT, P_DISCARD} phase_e;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    phase_e      m_ph = P_NONE;
    logic [31:0] m_req_pc = '0;
    ent_t        m_q[$];
    bit          owed = 1'b0;

    logic          r_val, r_ack, r_rv, r_fl, r_rdy;
    logic [31:0]   r_pc, r_rd;
    phase_e        ph_before;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_rdy();
        return n_rst && m_ph == P_NONE && m_q.size() < DEPTH && !fq_flush_in;
    endfunction

    function automatic bit m_byp();
`ifdef CORE_FQ_BYPASS_EN
        return n_rst && m_ph == P_AWAIT && fq_l1i_rvalid_in && m_q.size() == 0 && !fq_flush_in;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_check();
        ent_t e;
        bit   ev;
        check("pc_rdy", 32'(fq_pc_rdy_out), 32'(m_rdy()));
        check("l1i_val", 32'(fq_l1i_val_out), 32'(m_ph == P_ASK));
        if (m_ph == P_ASK) check("l1i_addr", fq_l1i_addr_out, m_req_pc);
        check("count", 32'(fq_count_out), 32'(m_q.size()));
        ev = (m_q.size() != 0) || m_byp();
        check("dec_val", 32'(dec_val_out), 32'(ev));
        if (ev) begin
            if (m_q.size() != 0) e = m_q[0];
            else e = '{pc: m_req_pc, instr: fq_l1i_rdata_in};
            check("dec_pc", dec_pc_out, e.pc);
            check("dec_instr", dec_instr_out, e.instr);
            check("dec_pc_4", dec_pc_4_out, e.pc + 32'd4);
        end
    endtask

    task automatic apply(input logic val, input logic [31:0] pc, input logic ack, input logic rv,
                         input logic [31:0] rd, input logic drdy, input logic fl);
        fq_pc_val_in = val; fq_pc_in = pc; fq_l1i_ack_in = ack; fq_l1i_rvalid_in = rv;
        fq_l1i_rdata_in = rd; dec_rdy_in = drdy; fq_flush_in = fl;
        #2;
        model_check();
    endtask

    task automatic advance();
        bit pop, push, acc;
        if (!n_rst) begin
            m_ph = P_NONE; m_req_pc = '0; m_q.delete();
        end else begin
            acc  = m_rdy() && fq_pc_val_in;
            pop  = m_q.size() != 0 && dec_rdy_in && !fq_flush_in;
            push = m_ph == P_AWAIT && fq_l1i_rvalid_in && !fq_flush_in && !(m_byp() && dec_rdy_in);
            if (fq_flush_in) m_q.delete();
            else begin
                if (pop)  void'(m_q.pop_front());
                if (push) m_q.push_back('{pc: m_req_pc, instr: fq_l1i_rdata_in});
            end
            case (m_ph)
                P_NONE:    if (acc) begin m_req_pc = fq_pc_in; m_ph = P_ASK; end
                P_ASK:     if (fq_l1i_ack_in) m_ph = fq_flush_in ? P_DISCARD : P_AWAIT;
                           else if (fq_flush_in) m_ph = P_NONE;
                P_AWAIT:   if (fq_l1i_rvalid_in) m_ph = P_NONE;
                           else if (fq_flush_in) m_ph = P_DISCARD;
                P_DISCARD: if (fq_l1i_rvalid_in && !fq_flush_in) m_ph = P_NONE;
                default:   m_ph = P_NONE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input logic drdy);
        apply(1'b1, pc, 1'b0, 1'b0, '0, drdy, 1'b0); advance();
        apply(1'b0, '0, 1'b1, 1'b0, '0, drdy, 1'b0); advance();
        apply(1'b0, '0, 1'b0, 1'b1, instr, drdy, 1'b0); advance();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"}, 32'(fq_pc_rdy_out), 32'd0);
        check({tag, "_addr"}, fq_l1i_addr_out, 32'd0);
        check({tag, "_l1i_val"}, 32'(fq_l1i_val_out), 32'd0);
        check({tag, "_instr"}, dec_instr_out, 32'd0);
        check({tag, "_pc"}, dec_pc_out, 32'd0);
        check({tag, "_pc4"}, dec_pc_4_out, 32'd0);
        check({tag, "_dval"}, 32'(dec_val_out), 32'd0);
        check({tag, "_count"}, 32'(fq_count_out), 32'd0);
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        apply(1'b1, 32'h100, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_all_zero("reset");
        advance();
        n_rst = 1'b1;

        // First fetch: accepted at N, ack N+1, rvalid N+2, decode sees it at N+3
        apply(1'b1, 32'h200, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("lat_accept", 32'(fq_pc_rdy_out), 32'd1);
        advance();
        apply(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("lat_l1i_addr", fq_l1i_addr_out, 32'h200);
        advance();
        apply(1'b0, '0, 1'b0, 1'b1, 32'h13, 1'b0, 1'b0);
`ifdef CORE_FQ_BYPASS_EN
        check("lat_byp_val", 32'(dec_val_out), 32'd1);
`else
        check("lat_n2_val", 32'(dec_val_out), 32'd0);
`endif
        advance();
        apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("lat_val", 32'(dec_val_out), 32'd1);
        check("lat_pc", dec_pc_out, 32'h200);
        check("lat_pc4", dec_pc_4_out, 32'h204);
        check("lat_instr", dec_instr_out, 32'h13);
        advance();
        apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0); advance();

        // Fill to DEPTH with decode stalled, then a single pop reopens the PC port
        for (int i = 0; i < DEPTH; i++) fetch(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
        apply(1'b1, 32'h2000, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("full_count", 32'(fq_count_out), 32'(DEPTH));
        check("full_rdy", 32'(fq_pc_rdy_out), 32'd0);
        advance();
        apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0); advance();
        apply(1'b1, 32'h2000, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("after_pop_rdy", 32'(fq_pc_rdy_out), 32'd1);
        advance();
        apply(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0); advance();
        apply(1'b0, '0, 1'b0, 1'b1, 32'hB0, 1'b0, 1'b0); advance();
        for (int i = 0; i < DEPTH; i++) begin apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0); advance(); end

        // Flush in WAIT with two queued entries, then the late response is dropped
        fetch(32'h3000, 32'hC0, 1'b0);
        fetch(32'h3004, 32'hC1, 1'b0);
        apply(1'b1, 32'h3008, 1'b0, 1'b0, '0, 1'b0, 1'b0); advance();
        apply(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0); advance();
        apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("flush_pre_count", 32'(fq_count_out), 32'd2);
        advance();
        apply(1'b1, 32'h3100, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("drop_count", 32'(fq_count_out), 32'd0);
        check("drop_dval", 32'(dec_val_out), 32'd0);
        check("drop_rdy", 32'(fq_pc_rdy_out), 32'd0);
        advance();
        apply(1'b0, '0, 1'b0, 1'b1, 32'hDEAD, 1'b1, 1'b0); advance();
        apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("dropped_dval", 32'(dec_val_out), 32'd0);
        check("dropped_rdy", 32'(fq_pc_rdy_out), 32'd1);
        advance();

        // Flush in REQ without ack withdraws; flush in WAIT with rvalid discards
        apply(1'b1, 32'h4000, 1'b0, 1'b0, '0, 1'b0, 1'b0); advance();
        apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1); advance();
        apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("withdraw_rdy", 32'(fq_pc_rdy_out), 32'd1);
        advance();
        apply(1'b1, 32'h4100, 1'b0, 1'b0, '0, 1'b0, 1'b0); advance();
        apply(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0); advance();
        apply(1'b0, '0, 1'b0, 1'b1, 32'h77, 1'b1, 1'b1); advance();
        apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("rv_flush_rdy", 32'(fq_pc_rdy_out), 32'd1);
        check("rv_flush_count", 32'(fq_count_out), 32'd0);
        advance();

        // PC+4 wraps at the top of the address space
        fetch(32'hFFFF_FFFC, 32'hBEEF, 1'b0);
        apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("wrap_pc", dec_pc_out, 32'hFFFF_FFFC);
        check("wrap_pc4", dec_pc_4_out, 32'h0000_0000);
        advance();

        // Simultaneous push and pop at count 2 across pointer wrap
        fetch(32'h5000, 32'h50, 1'b0);
        fetch(32'h5004, 32'h51, 1'b0);
        for (int k = 0; k < 8; k++) begin
            apply(1'b1, 32'h5008 + 32'(4 * k), 1'b0, 1'b0, '0, 1'b0, 1'b0); advance();
            apply(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0); advance();
            apply(1'b0, '0, 1'b0, 1'b1, 32'h52 + 32'(k), 1'b1, 1'b0);
            check("pp_head_pc", dec_pc_out, 32'h5000 + 32'(4 * k));
            advance();
            apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            check("pp_count", 32'(fq_count_out), 32'd2);
            advance();
        end
        for (int i = 0; i < 2; i++) begin apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0); advance(); end

        // Reset while a response is outstanding; the late response must be ignored
        apply(1'b1, 32'h6000, 1'b0, 1'b0, '0, 1'b0, 1'b0); advance();
        apply(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0); advance();
        n_rst = 1'b0;
        apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0); advance();
        apply(1'b1, 32'h6100, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_all_zero("rst_wait");
        advance();
        n_rst = 1'b1;
        apply(1'b0, '0, 1'b0, 1'b1, 32'h99, 1'b0, 1'b0); advance();
        apply(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("rst_late_count", 32'(fq_count_out), 32'd0);
        check("rst_late_dval", 32'(dec_val_out), 32'd0);
        advance();

        // Randomized traffic with a protocol-respecting L1I responder
        for (int i = 0; i < 600; i++) begin
            r_val = 1'($urandom % 2);
            r_pc  = ($urandom % 8 == 0) ? 32'hFFFF_FFFC : $urandom;
            r_ack = (m_ph == P_ASK) && ($urandom % 2 == 0);
            r_rv  = owed && ($urandom % 3 == 0);
            r_rd  = $urandom;
            r_rdy = 1'($urandom % 3 != 0);
            r_fl  = ($urandom % 12 == 0) && !(m_ph == P_DISCARD && r_rv);
            ph_before = m_ph;
            apply(r_val, r_pc, r_ack, r_rv, r_rd, r_rdy, r_fl);
            advance();
            if (r_rv) owed = 1'b0;
            if (r_ack && ph_before == P_ASK) owed = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/core_fetch_queue.md
CORE_FETCH_QUEUE -- requirements
Module: core_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of instruction queue entries (power of two, >=2).
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 The block SHALL have port n_rst  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port fq_pc_in  input  32  fetch address from the fetch stage PC.
REQ-005 The block SHALL have port fq_pc_val_in  input  1  fq_pc_in valid.
REQ-006 The block SHALL have port fq_pc_rdy_out  output  1  address accepted this cycle; the fetch stage advances its PC on val&rdy.
REQ-007 The block SHALL have port fq_flush_in  input  1  kill from hazard control; discards queued and in-flight fetches.
REQ-008 The block SHALL have port fq_l1i_addr_out  output  32  L1I request address.
REQ-009 The block SHALL have port fq_l1i_val_out  output  1  L1I request valid.
REQ-010 The block SHALL have port fq_l1i_ack_in  input  1  L1I request accepted.
REQ-011 The block SHALL have ports fq_l1i_rdata_in  input  32  and fq_l1i_rvalid_in  input  1  L1I instruction response; rvalid never in the ack cycle.
REQ-012 The block SHALL have ports dec_instr_out, dec_pc_out, dec_pc_4_out  output  32 each  head entry instruction, PC, PC+4 to decode.
REQ-013 The block SHALL have ports dec_val_out  output  1  and dec_rdy_in  input  1  decode handshake; pop on val&rdy.
REQ-014 The block SHALL have port fq_count_out  output  clog2(DEPTH)+1  current number of queued entries.

Function
REQ-015 The block SHALL run a control FSM with states IDLE, REQ, WAIT, DROP; at most one L1I request outstanding.
REQ-016 IDLE: fq_pc_rdy_out = (count<DEPTH) & ~fq_flush_in; on val&rdy the block SHALL latch fq_pc_in into req_pc and enter REQ.
REQ-017 REQ: fq_l1i_val_out=1, fq_l1i_addr_out=req_pc held stable; on ack enter WAIT.
REQ-018 WAIT: on rvalid the block SHALL push {req_pc, rdata} into the queue and enter IDLE.
REQ-019 fq_pc_rdy_out SHALL be 0 in REQ, WAIT, DROP; fq_l1i_val_out SHALL be 0 outside REQ.
REQ-020 Minimum latency: address accepted cycle N, ack N+1, rvalid N+2, dec_val_out=1 at N+3 (queue was empty).
REQ-021 Queue: circular buffer, read/write pointers wrap modulo DEPTH; dec_val_out = (count!=0); push and pop in the same cycle SHALL leave count unchanged.
REQ-022 dec_pc_4_out SHALL equal dec_pc_out+4 modulo 2^32.
REQ-023 Flush: count, pointers cleared next cycle, dec_val_out=0; flush in REQ without ack -> IDLE (request withdrawn); flush in REQ with ack, or in WAIT without rvalid -> DROP; flush in WAIT with rvalid -> IDLE, data discarded.
REQ-024 DROP: the block SHALL discard the next rvalid and enter IDLE; flush in DROP stays in DROP.
REQ-025 Flush takes priority over push and pop in the same cycle.

Reset
REQ-026 While n_rst=0 at a clock edge: state IDLE, req_pc=0, pointers=0, count=0.
REQ-027 After reset every output SHALL be 0 (fq_pc_rdy_out forced 0 while n_rst=0); an in-flight L1I response after reset SHALL be ignored because state is IDLE.

Configuration
REQ-028 Macro CORE_FQ_BYPASS_EN defined: in WAIT with rvalid and count=0, the response SHALL drive dec_* outputs the same cycle (dec_val_out=1); if dec_rdy_in=1 it is not written to the queue; minimum latency becomes N+2.
REQ-029 Macro CORE_FQ_BYPASS_EN undefined: every response SHALL be written to the queue before being presented.

Verification
REQ-030 Reset, pc=0x200 val, ack next cycle, rvalid rdata=0x00000013 after -> dec_pc_out=0x200, dec_pc_4_out=0x204, dec_instr_out=0x13 at N+3 (N+2 with bypass).
REQ-031 dec_rdy_in=0, fetch 4 addresses -> fq_count_out=4, fq_pc_rdy_out=0; one pop -> fq_pc_rdy_out=1 next IDLE cycle.
REQ-032 Flush in WAIT with queue holding 2 -> count=0, state DROP; next rvalid ignored, dec_val_out stays 0.
REQ-033 dec_pc_out=0xFFFFFFFC -> dec_pc_4_out=0x00000000.
REQ-034 Push and pop in same cycle at count=2 over 8 fetches -> count stays 2, entries delivered in order across pointer wrap.
REQ-035 n_rst=0 in WAIT -> all outputs 0 next cycle, subsequent rvalid not queued.
